btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
- Front-end controller for the board push-buttons. It synchronises and debounces N raw button inputs using one shared sample-tick prescaler.
- Each debounced press becomes a pending event. A round-robin arbiter serialises pending events onto a single valid/ready event port for the downstream FSM.
- Releases are tracked on the level outputs only and never generate events.

Parameters:
- N_BTN, 4, number of button inputs (≥2).
- ID_W, 2, event ID width; must satisfy 2^ID_W ≥ N_BTN.
- TICK_DIV, 1000, clk cycles per debounce sample tick (≥1; 1 = sample every cycle).
- DB_COUNT, 25, consecutive disagreeing samples required to accept a new level (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  N_BTN  raw asynchronous button levels, active-high.
- btn_level  output  N_BTN  debounced button levels.
- evt_valid  output  1  event offered.
- evt_id  output  ID_W  index of the button whose press is offered.
- evt_ready  input  1  consumer accepts the event when high together with evt_valid.
- overrun  output  1  sticky flag: a press arrived while the same button already had an event pending.

Behaviour:
- Reset: when rst is sampled high, the following are cleared to 0: synchronisers, prescaler, debounce counters, btn_level, pending, evt_valid, evt_id, overrun and rr_ptr. The FSM goes to IDLE.
  - Reset mid-offer drops the offered event and all pending events.
- Synchroniser: 2-FF per bit. sync[i] is btn_in[i] delayed 2 clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where the count equals TICK_DIV-1. With TICK_DIV=1, tick is constantly 1.
- Debounce, per button, evaluated only on tick cycles:
  - If sync[i] == btn_level[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DB_COUNT-1: btn_level[i] <= sync[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Counter width is clog2(DB_COUNT) (minimum 1). A single agreeing sample restarts the count.
  - Latency with TICK_DIV=1: raw edge sampled at edge k → btn_level changes after edge k+1+DB_COUNT.
- Press detect:
  - A 0→1 transition of btn_level[i] sets pending[i] on the following edge (registered edge detect).
  - If pending[i] is already 1 and is not being cleared in that cycle, overrun <= 1. overrun stays set until reset.
- Arbiter FSM, states IDLE and OFFER:
  - IDLE → OFFER when pending is non-zero. The next edge loads evt_id with the first set pending bit, searching upward from rr_ptr with wrap-around modulo N_BTN, and sets evt_valid <= 1. In IDLE, evt_valid = 0.
  - In OFFER, evt_valid = 1 and evt_id is held stable until handshake.
    - evt_ready low: remain in OFFER. Pending presses on other buttons do not change evt_id.
    - evt_ready high (handshake): clear pending[evt_id], set rr_ptr <= (evt_id+1) mod N_BTN, evt_valid <= 0, go to IDLE.
  - The FSM spends at least one cycle in IDLE between events, so maximum throughput is 1 event per 2 clk.
  - evt_ready while in IDLE is ignored.
- Simultaneous events:
  - A new press of the same button in its handshake cycle: set wins, pending stays 1, no overrun. The button is re-offered later per round-robin order.
  - Multiple presses in the same cycle: all pending bits are set, then served in round-robin order starting at rr_ptr.

Test Plan (TICK_DIV=1, DB_COUNT=4, N_BTN=4):
1. Reset hold: rst=1 for 3 cycles with btn_in=4'b1111 → all outputs 0. After release, btn_level=4'b1111 exactly 5 cycles after the first post-reset sample, and evt_valid rises 2 cycles later with evt_id=0.
2. Bounce rejection: btn_in[1] toggles 1,1,1,0,1,1,1,1 (one per cycle) → btn_level[1] rises only after the final 4 agreeing samples. Exactly one event is produced, with id=1.
3. Round-robin: buttons 0, 2 and 3 press in the same cycle, evt_ready=1 constantly → evt_id sequence 0, 2, 3 with evt_valid low for one cycle between each. A subsequent press of 0 and 3 yields 0, then 3.
4. Backpressure: evt_ready=0 for 20 cycles while offering id=2 and button 1 presses → evt_id stays 2. After evt_ready=1, id=2 then id=1 are delivered, and overrun stays 0.
5. Overrun: with evt_ready=0, press/release/press button 3 → overrun=1 and remains 1 after the handshake. Only one event with id=3 is delivered.
6. Reset mid-offer: rst=1 for 1 cycle while evt_valid=1 and 2 presses are pending → evt_valid=0 and pending is cleared. With buttons released, no events follow.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// Push-button front end: 2-FF synchronisers, tick-paced debouncers, press
// detection and a round-robin arbiter serialising presses onto a valid/ready port.
module btn_event_ctrl #(
  parameter int N_BTN    = 4,
  parameter int ID_W     = 2,
  parameter int TICK_DIV = 1000,
  parameter int DB_COUNT = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic             overrun
);

  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_BTN - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state, state_nxt;
  logic [N_BTN-1:0]   sync_p0, sync_p1;
  logic [PS_W-1:0]    ps_cnt;
  logic               tick;
  logic [CNT_W-1:0]   db_cnt [N_BTN];
  logic [N_BTN-1:0]   level_p2;
  logic [N_BTN-1:0]   rise;
  logic [N_BTN-1:0]   pending, pending_nxt, clr;
  logic               ovr_set;
  logic [ID_W-1:0]    rr_ptr, rr_nxt, sel_id;
  logic               load, hs;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst)       ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PS_W'(1);
  end

  // Stage p2: debounced level; any agreeing sample restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_p1[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          btn_level[i] <= sync_p1[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = btn_level & ~level_p2;

  // Stage p3: pending presses; a new press in its own handshake cycle wins
  always_comb begin
    clr = '0;
    if (hs) clr = N_BTN'(1) << evt_id;
    pending_nxt = (pending & ~clr) | rise;
    ovr_set     = |(rise & pending & ~clr);
  end

  // Round-robin pick: first pending bit at or above rr_ptr, wrapping modulo N_BTN
  always_comb begin
    sel_id = '0;
    for (int r = 0; r < N_BTN; r++) begin
      if (rr_ptr == ID_W'(r)) begin
        for (int k = N_BTN - 1; k >= 0; k--) begin
          if (pending[(r + k) % N_BTN]) sel_id = ID_W'((r + k) % N_BTN);
        end
      end
    end
  end

  assign rr_nxt = (evt_id == ID_LAST) ? '0 : evt_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_nxt = OFFER;
          load      = 1'b1;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_nxt = IDLE;
          hs        = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_p2 <= '0;
      pending  <= '0;
      overrun  <= 1'b0;
      evt_id   <= '0;
      rr_ptr   <= '0;
    end else begin
      level_p2 <= btn_level;
      pending  <= pending_nxt;
      if (ovr_set) overrun <= 1'b1;
      if (load)    evt_id  <= sel_id;
      if (hs)      rr_ptr  <= rr_nxt;
    end
  end

  assign evt_valid = (state == OFFER);

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed button stimulus, expected event IDs queued
// by the stimulus and checked by an independent handshake monitor.
module tb_btn_event_ctrl;
  localparam int N_BTN = 4;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             evt_ready;
  logic             overrun;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;
  logic [ID_W-1:0] exp_q[$];
  bit last_hs = 1'b0;

  btn_event_ctrl #(
    .N_BTN(N_BTN), .ID_W(ID_W), .TICK_DIV(1), .DB_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted event must match the head of the expected queue
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      last_hs <= 1'b0;
    end else begin
      if (last_hs) check("evt_gap", {31'd0, evt_valid}, 0);
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        hs_count <= hs_count + 1;
        check("evt_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) check("evt_id", {30'd0, evt_id}, {30'd0, exp_q.pop_front()});
        last_hs <= 1'b1;
      end else begin
        last_hs <= 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && evt_valid === 1'b0) break;
      step();
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_idle", {31'd0, evt_valid}, 0);
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      if (evt_valid === 1'b1) break;
      step();
    end
    check("wait_valid", {31'd0, evt_valid}, 1);
  endtask

  task automatic release_all();
    btn_in = '0;
    repeat (10) step();
    check("released", {28'd0, btn_level}, 0);
  endtask

  task automatic do_reset();
    btn_in = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit [0:7] pat;
    int stable;
    int h0;

    // 1: reset hold with all buttons pressed
    rst = 1'b1; btn_in = 4'b1111; evt_ready = 1'b1;
    step();
    check("rst_level", {28'd0, btn_level}, 0);
    check("rst_valid", {31'd0, evt_valid}, 0);
    check("rst_id", {30'd0, evt_id}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    step(); step();
    check("rst_level_hold", {28'd0, btn_level}, 0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    rst = 1'b0;
    repeat (5) step();
    check("lvl_before", {28'd0, btn_level}, 0);
    step();
    check("lvl_rise", {28'd0, btn_level}, 4'hf);
    step();
    check("valid_early", {31'd0, evt_valid}, 0);
    step();
    check("valid_rise", {31'd0, evt_valid}, 1);
    check("first_id", {30'd0, evt_id}, 0);
    drain(40);
    release_all();

    // 2: bounce rejection on button 1
    pat = 8'b1110_1111;
    exp_q.push_back(2'd1);
    for (int i = 0; i < 8; i++) begin
      btn_in[1] = pat[i];
      step();
    end
    step();
    check("bounce_hold", {31'd0, btn_level[1]}, 0);
    step();
    check("bounce_rise", {31'd0, btn_level[1]}, 1);
    drain(40);
    release_all();

    // 3: simultaneous presses served round-robin
    do_reset();
    btn_in = 4'b1101;
    exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    drain(60);
    release_all();
    btn_in = 4'b1001;
    exp_q.push_back(2'd0); exp_q.push_back(2'd3);
    drain(60);
    release_all();
    check("rr_overrun", {31'd0, overrun}, 0);

    // 4: backpressure holds the offered id
    evt_ready = 1'b0;
    btn_in = 4'b0100;
    wait_valid(30);
    check("bp_first_id", {30'd0, evt_id}, 2);
    btn_in = 4'b0110;
    stable = 0;
    repeat (20) begin
      step();
      if (evt_valid === 1'b1 && evt_id === 2'd2) stable++;
    end
    check("bp_hold", stable, 20);
    exp_q.push_back(2'd2); exp_q.push_back(2'd1);
    evt_ready = 1'b1;
    drain(40);
    check("bp_overrun", {31'd0, overrun}, 0);
    release_all();

    // 5: second press of button 3 while its event is still pending
    evt_ready = 1'b0;
    btn_in = 4'b1000;
    wait_valid(30);
    check("ovr_id", {30'd0, evt_id}, 3);
    btn_in = 4'b0000;
    repeat (10) step();
    check("ovr_before", {31'd0, overrun}, 0);
    btn_in = 4'b1000;
    repeat (10) step();
    check("ovr_set", {31'd0, overrun}, 1);
    exp_q.push_back(2'd3);
    evt_ready = 1'b1;
    drain(40);
    check("ovr_sticky", {31'd0, overrun}, 1);
    release_all();
    check("ovr_sticky_late", {31'd0, overrun}, 1);

    // 6: reset while offering with two presses pending
    evt_ready = 1'b0;
    btn_in = 4'b0011;
    wait_valid(30);
    check("mid_id", {30'd0, evt_id}, 0);
    step();
    btn_in = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, evt_valid}, 0);
    check("mid_rst_overrun", {31'd0, overrun}, 0);
    check("mid_rst_level", {28'd0, btn_level}, 0);
    evt_ready = 1'b1;
    h0 = hs_count;
    repeat (20) step();
    check("no_evt_after_rst", hs_count - h0, 0);

    check("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
